peripheral_ram_slave_ahb3: RTL and testbench

//   AHB3-Lite slave front-end for the single-port generic RAM (clk, we[3:0], din, waddr, raddr, dout).

---
 rtl/peripheral_ram_slave_ahb3.sv | 118 +++++++++++
 tb/tb_peripheral_ram_slave_ahb3.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_ram_slave_ahb3.sv
// AHB3-Lite slave front-end for a single-port byte-writable RAM with 1-cycle registered read.
// Zero-wait reads, write-to-read forwarding on the same word, and a two-cycle ERROR response.
module peripheral_ram_slave_ahb3 #(
    parameter int DEPTH      = 256,
    parameter int AW         = $clog2(DEPTH),
    parameter int DW         = 32,
    parameter int HADDR_SIZE = 32
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [DW-1:0]         HWDATA,
    output logic [DW-1:0]         HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [3:0]            ram_we,
    output logic [DW-1:0]         ram_din,
    output logic [AW-1:0]         ram_waddr,
    output logic [AW-1:0]         ram_raddr,
    input  logic [DW-1:0]         ram_dout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RDATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    be_reg;
    logic [AW-1:0] idx_reg;
    logic [3:0]    fwd_be_reg;
    logic [DW-1:0] fwd_data_reg;

    logic          accept;
    logic          illegal;
    logic [3:0]    be;
    logic [AW-1:0] idx;
    logic          hazard;
    logic [DW-1:0] rd_merged;

    logic unused;
    assign unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[HADDR_SIZE-1:AW+2]};

    assign accept = HSEL & HREADY & HTRANS[1];
    assign idx    = HADDR[AW+1:2];

    always_comb begin
        illegal = 1'b0;
        be      = 4'b1111;
        unique case (HSIZE)
            3'd0: be = 4'(4'b0001 << HADDR[1:0]);
            3'd1: begin
                be      = 4'(4'b0011 << HADDR[1:0]);
                illegal = HADDR[0];
            end
            3'd2: illegal = (HADDR[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_next = ST_IDLE;
        if (state_reg == ST_ERR1)
            state_next = ST_ERR2;
        else if (accept)
            state_next = illegal ? ST_ERR1 : (HWRITE ? ST_WDATA : ST_RDATA);
    end

    // Same-word read issued during a write data phase sees stale RAM data; capture the write.
    assign hazard = accept & ~illegal & ~HWRITE & (state_reg == ST_WDATA) & (idx == idx_reg);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg    <= ST_IDLE;
            be_reg       <= 4'b0000;
            idx_reg      <= '0;
            fwd_be_reg   <= 4'b0000;
            fwd_data_reg <= '0;
        end else begin
            state_reg  <= state_next;
            fwd_be_reg <= hazard ? ram_we : 4'b0000;
            if (hazard)
                fwd_data_reg <= HWDATA;
            if (accept) begin
                be_reg  <= be;
                idx_reg <= idx;
            end
        end
    end

    assign ram_we    = (state_reg == ST_WDATA) ? be_reg : 4'b0000;
    assign ram_waddr = idx_reg;
    assign ram_din   = HWDATA;
    assign ram_raddr = idx;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_merged[gi*8 +: 8] = fwd_be_reg[gi] ? fwd_data_reg[gi*8 +: 8]
                                                         : ram_dout[gi*8 +: 8];
        end
    endgenerate

    assign HRDATA    = (state_reg == ST_RDATA) ? rd_merged : '0;
    assign HREADYOUT = (state_reg != ST_ERR1);
    assign HRESP     = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);

endmodule

// File: tb/tb_peripheral_ram_slave_ahb3.sv
// Directed bench: vector table of single AHB transfers plus pipelined sequences
// for forwarding, back-to-back writes, error handoff and reset during a write.
module tb_peripheral_ram_slave_ahb3;

    logic        HRESETn, HCLK;
    logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP, HMASTLOCK;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [3:0]  ram_we;
    logic [31:0] ram_din, ram_dout;
    logic [7:0]  ram_waddr, ram_raddr;

    int vec_cnt = 0;
    int err_cnt = 0;

    peripheral_ram_slave_ahb3 dut (
        .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(HSEL), .HADDR(HADDR),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .ram_we(ram_we), .ram_din(ram_din), .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Single-slave bus: HREADY follows this slave's HREADYOUT
    assign HREADY = HREADYOUT;

    // RAM model: byte writes and registered read (read-during-write returns old data)
    logic [31:0] mem [0:255];
    always @(posedge HCLK) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_waddr][i*8 +: 8] <= ram_din[i*8 +: 8];
        ram_dout <= mem[ram_raddr];
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_we;
        logic        err;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end else
            $display("ok   %s: 0x%08h", nm, act);
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        HSEL = 1'b1; HTRANS = 2'd2; HWRITE = wr; HADDR = a; HSIZE = sz;
    endtask

    task automatic idle_bus();
        HTRANS = 2'd0; HWRITE = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        @(posedge HCLK); #1;
        addr_phase(v.wr, v.addr, v.size);
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = v.wdata;
        @(negedge HCLK);
        if (v.err) begin
            chk({nm, " err1 resp/ready"}, {30'd0, HRESP, HREADYOUT}, 32'd2);
            chk({nm, " err1 we"}, {28'd0, ram_we}, 32'd0);
            @(posedge HCLK); #1;
            @(negedge HCLK);
            chk({nm, " err2 resp/ready"}, {30'd0, HRESP, HREADYOUT}, 32'd3);
            chk({nm, " err2 we"}, {28'd0, ram_we}, 32'd0);
        end else begin
            chk({nm, " resp/ready"}, {30'd0, HRESP, HREADYOUT}, 32'd1);
            if (v.wr) begin
                chk({nm, " we"}, {28'd0, ram_we}, {28'd0, v.exp_we});
                chk({nm, " waddr"}, {24'd0, ram_waddr}, {24'd0, v.addr[9:2]});
            end else
                chk({nm, " rdata"}, HRDATA, v.exp_rdata);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        vec_t v;
        v = '{1'b0, a, 3'd2, 32'h0, exp, 4'h0, 1'b0};
        run_vec(v, nm);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string nm);
        vec_t v;
        v = '{1'b1, a, 3'd2, d, 32'h0, 4'hF, 1'b0};
        run_vec(v, nm);
    endtask

    // Word write immediately followed by a read; checks the data-phase HRDATA
    task automatic wr_then_rd(input logic [31:0] wa, input logic [2:0] wsz, input logic [31:0] wd,
                              input logic [31:0] ra, input logic [31:0] exp, input string nm);
        @(posedge HCLK); #1;
        addr_phase(1'b1, wa, wsz);
        @(posedge HCLK); #1;
        HWDATA = wd;
        addr_phase(1'b0, ra, 3'd2);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk({nm, " rdata"}, HRDATA, exp);
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 32'h0,        4'hF, 1'b0};
        vt[1]  = '{1'b0, 32'h010, 3'd2, 32'h0,        32'hDEADBEEF, 4'h0, 1'b0};
        vt[2]  = '{1'b1, 32'h010, 3'd2, 32'h11223344, 32'h0,        4'hF, 1'b0};
        vt[3]  = '{1'b1, 32'h013, 3'd0, 32'hAA000000, 32'h0,        4'h8, 1'b0};
        vt[4]  = '{1'b0, 32'h010, 3'd2, 32'h0,        32'hAA223344, 4'h0, 1'b0};
        vt[5]  = '{1'b1, 32'h018, 3'd2, 32'hCAFEF00D, 32'h0,        4'hF, 1'b0};
        vt[6]  = '{1'b1, 32'h01A, 3'd1, 32'h12340000, 32'h0,        4'hC, 1'b0};
        vt[7]  = '{1'b1, 32'h019, 3'd0, 32'h00005A00, 32'h0,        4'h2, 1'b0};
        vt[8]  = '{1'b0, 32'h01B, 3'd0, 32'h0,        32'h12345A0D, 4'h0, 1'b0};
        vt[9]  = '{1'b1, 32'h021, 3'd1, 32'h0,        32'h0,        4'h0, 1'b1};
        vt[10] = '{1'b1, 32'h022, 3'd2, 32'h0,        32'h0,        4'h0, 1'b1};
        vt[11] = '{1'b0, 32'h030, 3'd3, 32'h0,        32'h0,        4'h0, 1'b1};
        vt[12] = '{1'b0, 32'h011, 3'd2, 32'h0,        32'h0,        4'h0, 1'b1};
        vt[13] = '{1'b1, 32'h3FC, 3'd2, 32'h0BADF00D, 32'h0,        4'hF, 1'b0};
        vt[14] = '{1'b0, 32'h3FC, 3'd2, 32'h0,        32'h0BADF00D, 4'h0, 1'b0};
        vt[15] = '{1'b0, 32'h410, 3'd2, 32'h0,        32'hAA223344, 4'h0, 1'b0};

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
        HSIZE = 3'd2; HBURST = 3'd0; HPROT = 4'h3; HTRANS = 2'd0; HMASTLOCK = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("reset resp/ready", {30'd0, HRESP, HREADYOUT}, 32'd1);
        chk("reset we", {28'd0, ram_we}, 32'd0);
        chk("reset rdata", HRDATA, 32'd0);
        HRESETn = 1'b1;

        for (int i = 0; i < 16; i++)
            run_vec(vt[i], $sformatf("vec%0d", i));

        // Full-word forwarding, then partial-lane forwarding merged with RAM data
        do_write(32'h020, 32'h00000000, "init 0x20");
        wr_then_rd(32'h020, 3'd2, 32'h55667788, 32'h020, 32'h55667788, "fwd word");
        do_write(32'h024, 32'h11111111, "init 0x24");
        wr_then_rd(32'h025, 3'd0, 32'h0000BB00, 32'h024, 32'h1111BB11, "fwd byte");
        do_read(32'h024, 32'h1111BB11, "after fwd 0x24");
        wr_then_rd(32'h02C, 3'd2, 32'h77777777, 32'h020, 32'h55667788, "no fwd other word");

        // Back-to-back writes to one word: last beat wins
        @(posedge HCLK); #1;
        addr_phase(1'b1, 32'h028, 3'd2);
        @(posedge HCLK); #1;
        HWDATA = 32'hAAAAAAAA;
        @(negedge HCLK);
        chk("b2b beat1 we", {28'd0, ram_we}, 32'hF);
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = 32'hBBBBBBBB;
        @(negedge HCLK);
        chk("b2b beat2 we", {28'd0, ram_we}, 32'hF);
        do_read(32'h028, 32'hBBBBBBBB, "b2b readback");

        // Error, then a read presented during ERR2 must be accepted
        @(posedge HCLK); #1;
        addr_phase(1'b1, 32'h021, 3'd1);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk("errseq err1", {26'd0, HRESP, HREADYOUT, ram_we}, 32'h20);
        @(posedge HCLK); #1;
        addr_phase(1'b0, 32'h018, 3'd2);
        @(negedge HCLK);
        chk("errseq err2", {26'd0, HRESP, HREADYOUT, ram_we}, 32'h30);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk("errseq read rdata", HRDATA, 32'h12345A0D);
        chk("errseq read resp/ready", {30'd0, HRESP, HREADYOUT}, 32'd1);

        // Reset asserted in the middle of a write data phase
        @(posedge HCLK); #1;
        addr_phase(1'b1, 32'h010, 3'd2);
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = 32'hFFFFFFFF;
        chk("rst pre we", {28'd0, ram_we}, 32'hF);
        HRESETn = 1'b0;
        #1;
        chk("rst we", {28'd0, ram_we}, 32'd0);
        chk("rst resp/ready", {30'd0, HRESP, HREADYOUT}, 32'd1);
        chk("rst rdata", HRDATA, 32'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        do_read(32'h010, 32'hAA223344, "rst word kept");

        // Selected but IDLE for four cycles
        HSEL = 1'b1; HTRANS = 2'd0; HADDR = 32'h010; HWRITE = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge HCLK);
            chk($sformatf("idle cyc%0d", c), {26'd0, HRESP, HREADYOUT, ram_we}, 32'h10);
        end
        HWRITE = 1'b0;
        HSEL = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
